// File: rtl/muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl_if
// Brief    : EX-stage <-> M-extension sequencer handshake and operand bus.
// Revision : 1.0
// ============================================================================
interface muldiv_ctrl_if #(
   parameter int XLEN = 32
) ();
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            flush;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, funct3, op_a, op_b, flush,
      input  stall, done, result
   );

   modport slave (
      input  start, funct3, op_a, op_b, flush,
      output stall, done, result
   );
endinterface
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Brief    : RV32M iterative shift-add multiply / restoring divide sequencer.
//            Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
// Revision : 1.0
// ============================================================================
module muldiv_ctrl #(
   parameter int XLEN = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   muldiv_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [2:0] C_MUL    = 3'b000;
   localparam logic [2:0] C_MULH   = 3'b001;
   localparam logic [2:0] C_MULHSU = 3'b010;
   localparam logic [2:0] C_MULHU  = 3'b011;
   localparam logic [2:0] C_DIV    = 3'b100;
   localparam logic [2:0] C_DIVU   = 3'b101;
   localparam logic [2:0] C_REM    = 3'b110;
   localparam logic [2:0] C_REMU   = 3'b111;

   localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state_q, state_d;
   logic [2:0]        f3_q, f3_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opd_q, opd_d;
   logic              neg_q, neg_d;
   logic              rneg_q, rneg_d;
   logic              done_q, done_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              w_accept;
   logic              w_a_sgn, w_b_sgn;
   logic              w_a_neg, w_b_neg;
   logic [XLEN-1:0]   w_mag_a, w_mag_b;
   logic              w_div_zero, w_ovf, w_early;
   logic [XLEN-1:0]   w_early_res;
   logic [XLEN:0]     w_mul_sum;
   logic [2*XLEN-1:0] w_mul_next;
   logic [XLEN:0]     w_trial;
   logic [2*XLEN-1:0] w_div_next;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quo, w_rem;
   logic [XLEN-1:0]   w_fix_res;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] w_fast_prod;
`endif

   // Operand decode: magnitudes and sign flags for the incoming instruction
   always_comb begin
      w_accept    = (state_q == S_IDLE) && bus.start && !bus.flush;
      w_a_sgn     = (bus.funct3 == C_MULH) || (bus.funct3 == C_MULHSU) ||
                    (bus.funct3 == C_DIV)  || (bus.funct3 == C_REM);
      w_b_sgn     = (bus.funct3 == C_MULH) || (bus.funct3 == C_DIV) ||
                    (bus.funct3 == C_REM);
      w_a_neg     = w_a_sgn && bus.op_a[XLEN-1];
      w_b_neg     = w_b_sgn && bus.op_b[XLEN-1];
      w_mag_a     = w_a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
      w_mag_b     = w_b_neg ? (~bus.op_b + 1'b1) : bus.op_b;
      w_div_zero  = (bus.op_b == '0);
      w_ovf       = ((bus.funct3 == C_DIV) || (bus.funct3 == C_REM)) &&
                    (bus.op_a == C_INT_MIN) && (bus.op_b == '1);
      w_early     = bus.funct3[2] && (w_div_zero || w_ovf);
      if (w_div_zero) begin
         w_early_res = bus.funct3[1] ? bus.op_a : '1;
      end else begin
         w_early_res = bus.funct3[1] ? '0 : bus.op_a;
      end
   end

`ifdef MULDIV_FAST_MUL_EN
   assign w_fast_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
`endif

   // One iteration step: multiply keeps {hi, multiplier} and shifts right;
   // divide keeps {rem, quo} and shifts left with a 33-bit trial subtract.
   always_comb begin
      w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                   (acc_q[0] ? {1'b0, opd_q} : {(XLEN+1){1'b0}});
      w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};
      w_trial    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opd_q};
      if (w_trial[XLEN]) begin
         w_div_next = {acc_q[2*XLEN-2:0], 1'b0};
      end else begin
         w_div_next = {w_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end
   end

   // Sign correction and output select
   always_comb begin
      w_prod = neg_q  ? (~acc_q + 1'b1) : acc_q;
      w_quo  = neg_q  ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
      w_rem  = rneg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
      case (f3_q)
         C_MUL:                     w_fix_res = w_prod[XLEN-1:0];
         C_MULH, C_MULHSU, C_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
         C_DIV, C_DIVU:             w_fix_res = w_quo;
         default:                   w_fix_res = w_rem;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      f3_d     = f3_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opd_d    = opd_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      done_d   = 1'b0;
      result_d = result_q;

      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               f3_d   = bus.funct3;
               neg_d  = w_a_neg ^ w_b_neg;
               rneg_d = w_a_neg;
               cnt_d  = '0;
               if (w_early) begin
                  result_d = w_early_res;
                  done_d   = 1'b1;
                  state_d  = S_DONE;
               end else if (bus.funct3[2]) begin
                  acc_d   = {{XLEN{1'b0}}, w_mag_a};
                  opd_d   = w_mag_b;
                  state_d = S_CALC;
               end else begin
`ifdef MULDIV_FAST_MUL_EN
                  acc_d   = w_fast_prod;
                  opd_d   = w_mag_a;
                  state_d = S_FIX;
`else
                  acc_d   = {{XLEN{1'b0}}, w_mag_b};
                  opd_d   = w_mag_a;
                  state_d = S_CALC;
`endif
               end
            end
         end
         S_CALC: begin
            acc_d = f3_q[2] ? w_div_next : w_mul_next;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            result_d = w_fix_res;
            done_d   = 1'b1;
            state_d  = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A squash abandons the operation without touching the visible result
      if (bus.flush) begin
         state_d  = S_IDLE;
         done_d   = 1'b0;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         f3_q     <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         opd_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         f3_q     <= f3_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opd_q    <= opd_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign bus.stall  = ((state_q == S_IDLE) && bus.start && !bus.flush) ||
                       (state_q == S_CALC) || (state_q == S_FIX);
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_ctrl
// Brief    : Self-checking bench for muldiv_ctrl (vector table + random ops).
// Revision : 1.0
// ============================================================================
module tb_muldiv_ctrl;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   logic [31:0] last_exp;

   muldiv_ctrl_if #(.XLEN(32)) bus ();

   muldiv_ctrl #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // RISC-V M-extension semantics from plain integer arithmetic
   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      int          ia, ib;
      ia = a;
      ib = b;
      sa = longint'(ia);
      sb = longint'(ib);
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      case (f3)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return ia / ib;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      bit is_signed_div;
      is_signed_div = (f3 == 3'd4) || (f3 == 3'd6);
      if (f3[2] && (b == 0 || (is_signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!f3[2]) return 2;
`endif
      return 34;
   endfunction

   // Issue one op at cycle 0 and hold start while stalled, as EX would
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic stall_bad,
                        output logic done_c0, output logic [31:0] res_c0);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = f3;
      bus.op_a   = a;
      bus.op_b   = b;
      bus.flush  = 1'b0;
      #1;
      done_c0   = bus.done;
      res_c0    = bus.result;
      stall_bad = (bus.stall !== 1'b1);
      lat       = -1;
      res       = 'x;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         #1;
         if (bus.done === 1'b1) begin
            lat = c;
            res = bus.result;
            stall_bad = stall_bad | (bus.stall !== 1'b0);
            break;
         end
         stall_bad = stall_bad | (bus.stall !== 1'b1);
      end
      bus.start = 1'b0;
   endtask

   task automatic run_checked(input string name, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp);
      logic [31:0] res, res_c0;
      int          lat;
      logic        sb, d0;
      do_op(f3, a, b, res, lat, sb, d0, res_c0);
      check({name, ".held"}, res_c0, last_exp);
      check({name, ".done_c0"}, {31'b0, d0}, 32'h0);
      check({name, ".result"}, res, exp);
      check({name, ".latency"}, lat, exp_lat(f3, a, b));
      check({name, ".stall"}, {31'b0, sb}, 32'h0);
      last_exp = exp;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   vec_t vecs[12];

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      last_exp   = 32'h0;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.flush  = 1'b0;
      bus.funct3 = 3'd0;
      bus.op_a   = 32'h0;
      bus.op_b   = 32'h0;

      vecs[0]  = '{"mul_7x-3",   3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vecs[1]  = '{"mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[2]  = '{"mulhu_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[3]  = '{"mulhsu_m1",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[4]  = '{"div_-7/2",   3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
      vecs[5]  = '{"rem_-7/2",   3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
      vecs[6]  = '{"divu_100/7", 3'd5, 32'd100,       32'd7,         32'd14};
      vecs[7]  = '{"remu_100/7", 3'd7, 32'd100,       32'd7,         32'd2};
      vecs[8]  = '{"div_5/0",    3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF};
      vecs[9]  = '{"rem_5/0",    3'd6, 32'd5,         32'd0,         32'd5};
      vecs[10] = '{"div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      vecs[11] = '{"rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset.stall",  {31'b0, bus.stall}, 32'h0);
      check("reset.done",   {31'b0, bus.done},  32'h0);
      check("reset.result", bus.result,         32'h0);

      for (int i = 0; i < 12; i++) begin
         run_checked(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);
      end

      // Flush mid-divide: prior result must survive, no done pulse
      run_checked("divu_pre", 3'd5, 32'd100, 32'd7, 32'd14);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = 3'd5;
      bus.op_a   = 32'd1000;
      bus.op_b   = 32'd3;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         #1;
         check("flush.no_done_calc", {31'b0, bus.done}, 32'h0);
      end
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      bus.start = 1'b0;
      #1;
      check("flush.idle_stall", {31'b0, bus.stall}, 32'h0);
      check("flush.no_done",    {31'b0, bus.done},  32'h0);
      check("flush.result",     bus.result,         32'd14);
      run_checked("divu_after_flush", 3'd5, 32'd1000, 32'd3, 32'd333);

      // Flush arriving together with start in IDLE: nothing accepted
      @(negedge clk);
      bus.start  = 1'b1;
      bus.flush  = 1'b1;
      bus.funct3 = 3'd4;
      bus.op_a   = 32'd9;
      bus.op_b   = 32'd0;
      #1;
      check("flush_start.stall", {31'b0, bus.stall}, 32'h0);
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = 1'b0;
      #1;
      check("flush_start.no_done", {31'b0, bus.done}, 32'h0);
      check("flush_start.result",  bus.result,        32'd333);

      // Asynchronous reset in the middle of CALC
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = 3'd5;
      bus.op_a   = 32'd5000;
      bus.op_b   = 32'd7;
      repeat (5) @(negedge clk);
      #1;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      #1;
      check("midreset.stall",  {31'b0, bus.stall}, 32'h0);
      check("midreset.done",   {31'b0, bus.done},  32'h0);
      check("midreset.result", bus.result,         32'h0);
      @(negedge clk);
      rst_n    = 1'b1;
      last_exp = 32'h0;
      run_checked("mul_3x4", 3'd0, 32'd3, 32'd4, 32'd12);

      // Random operations against the arithmetic reference model
      for (int i = 0; i < 150; i++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         f3 = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         run_checked("rand", f3, a, b, ref_result(f3, a, b));
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the RV32M multiply/divide unit in the execute stage of the pipelined core. It accepts one M-extension operation from EX and runs an iterative 32-step shift-add multiply or restoring divide on a shared accumulator. It stalls the pipeline while the operation is in progress and returns a one-cycle result strobe. Divide-by-zero and signed-overflow cases are resolved early, following the RISC-V spec.

## Interface
- `XLEN`, 32: operand and result width; must be 32.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: EX holds a valid M-extension instruction (opcode 0110011, funct7 0000001).
- `funct3` input 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a` input XLEN: rs1 value (multiplicand / dividend).
- `op_b` input XLEN: rs2 value (multiplier / divisor).
- `flush` input 1: EX is being squashed; aborts any operation.
- `stall` output 1: hold IF/ID/EX; combinational.
- `done` output 1: `result` valid this cycle; registered.
- `result` output XLEN: operation result; registered.

## Operation
- **States:** IDLE, CALC, FIX, DONE. Reset puts the block in IDLE with `done`=0, `result`=0, counter=0 and accumulators=0.
- **Accept:** an operation is accepted in IDLE when `start`=1 and `flush`=0. On accept, latch `funct3`, latch abs(op_a)/abs(op_b) per signedness, and latch the negate flags.
  - MULH: both operands signed.
  - MULHSU: `op_a` signed only.
  - DIV/REM: both signed.
  - MULHU/DIVU/REMU/MUL: unsigned magnitudes. MUL takes the low word, which is sign-agnostic.
- **Early cases (IDLE→DONE directly):**
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `op_a`.
  - Signed DIV/REM with `op_a`=0x80000000 and `op_b`=0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
- **CALC:** 32 iterations, counter 0..31, one bit per cycle.
  - Multiply: 64-bit product register, shift-add on the LSB of the multiplier.
  - Divide: restoring. Shift the {rem, quo} pair, trial-subtract the divisor, set the quotient bit if there is no borrow.
  - Counter 31 → FIX.
- **FIX:** apply sign correction.
  - Multiply: negate the 64-bit product if the negate flag is set.
  - Divide: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - Select the output: MUL gives product[31:0]; MULH/MULHSU/MULHU give product[63:32]. Register it into `result` → DONE.
- **DONE:** `done`=1 for exactly one cycle, `result` held → IDLE. `result` keeps its value until the next completion.
- **Stall:** `stall` = (IDLE & `start` & ~`flush`) | CALC | FIX. `stall` is 0 in DONE so EX advances and captures `result`.
- **Flush:** in any state, `flush`=1 → IDLE next cycle. No `done` is produced and `result` is unchanged. If `flush` and `start` arrive in the same IDLE cycle, `flush` wins and nothing is accepted.
- `start` outside IDLE is ignored. EX holds the instruction because `stall` is high.
- **Reset mid-operation:** immediate return to IDLE, all outputs take reset values.

## Timing
- Accept edge = cycle 0. CALC occupies cycles 1–32, FIX is cycle 33, and `done`=1 in cycle 34.
- `stall` is high in cycles 0–33.
- Early cases: `done`=1 in cycle 1; `stall` is high in cycle 0 only.
- Back-to-back: the next `start` can be accepted in the cycle after DONE.
- Arithmetic:
  - Product register is 64 bits.
  - Divide subtraction is 33 bits; the borrow is bit 32.
  - Negation is two's complement at full width.
  - abs(0x80000000) = 0x80000000, interpreted unsigned.

## Configuration
- `MULDIV_FAST_MUL_EN`
  - **Defined:** MUL/MULH/MULHSU/MULHU compute a combinational 64-bit product of the magnitudes on accept and go IDLE→FIX→DONE. `done` is in cycle 2 and `stall` is high in cycles 0–1. Divides are unchanged.
  - **Undefined:** all operations use the iterative CALC path with the 34-cycle latency above.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → `done` in cycle 34 (cycle 2 with the fast path), `result`=0xFFFFFFEB, `stall` high cycles 0–33.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, each with `done` in cycle 1. DIV 0x80000000 / −1 → 0x80000000; REM of the same operands → 0.
- Flush at cycle 10 of a DIVU → IDLE at cycle 11, no `done` pulse, previous `result` retained. A new DIVU accepted at cycle 12 → `done` at cycle 46.
- `rst_n` asserted low mid-CALC → `stall`=0, `done`=0, `result`=0 immediately. After release, MUL 3 × 4 → 12.
